gate_checker: RTL
=================

GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: extra cycles each test vector is held before dut_y is compared; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a test run; sampled only in IDLE.
REQ-005 gate_sel  input  3  gate under test: 0 AND, 1 OR, 2 NOT, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-006 dut_a  output  1  stimulus to the gate input a.
REQ-007 dut_b  output  1  stimulus to the gate input b; the NOT gate ignores it.
REQ-008 dut_y  input  1  gate output under test.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  one-cycle pulse at the end of a run.
REQ-011 pass  output  1  run completed with zero mismatches; held until the next accepted start.
REQ-012 invalid  output  1  last run requested gate_sel=7; held until the next accepted start.
REQ-013 err_count  output  3  number of mismatching vectors in the last run, 0..4.
REQ-014 first_fail_vec  output  2  {a,b} of the first mismatching vector; valid only when err_count!=0.

Function
REQ-015 The FSM has states IDLE, SETTLE, COMPARE and DONE.
REQ-016 In IDLE with start=1 at edge E0: gate_sel is latched; pass, invalid, err_count and first_fail_vec are cleared; busy rises.
REQ-017 If the latched gate_sel is 0..6, the FSM enters SETTLE at E0 and vector 0 ({a,b}=00) is driven from E0.
REQ-018 Vectors are applied in the order 00, 01, 10, 11; dut_a is the MSB of the vector index and dut_b is the LSB.
REQ-019 Each vector is held for exactly SETTLE_CYCLES+1 cycles.
REQ-020 dut_y is compared against the expected value at the last edge of each vector's hold period.
REQ-021 The next vector is driven from the same edge as the previous vector's comparison.
REQ-022 Expected values: AND a&b; OR a|b; NOT ~a; NAND ~(a&b); NOR ~(a|b); XOR a^b; XNOR ~(a^b).
REQ-023 On a mismatch, err_count increments by 1.
REQ-024 On the first mismatch of a run, first_fail_vec captures that vector's {a,b}.
REQ-025 The final comparison occurs at edge E(4*(SETTLE_CYCLES+1)).
REQ-026 At the final-comparison edge: the FSM enters DONE; done=1 for one cycle; busy=0; pass=(final err_count==0).
REQ-027 The FSM then returns to IDLE.
REQ-028 gate_sel=7: at E0, enter DONE with invalid=1, pass=0 and err_count=0; done pulses in the cycle following E0.
REQ-029 start is ignored while busy=1 and while in DONE.
REQ-030 A new start is accepted on the first IDLE cycle after DONE.
REQ-031 Changes on gate_sel during a run have no effect on that run.
REQ-032 dut_a and dut_b are 0 whenever the FSM is outside SETTLE/COMPARE.
REQ-033 All outputs are registered.
REQ-034 dut_y is used only at comparison edges.

Reset
REQ-035 rst_n=0 immediately forces IDLE, regardless of clk.
REQ-036 rst_n=0 forces dut_a=0, dut_b=0, busy=0, done=0, pass=0, invalid=0, err_count=0 and first_fail_vec=0.
REQ-037 A reset mid-run aborts the run with no done pulse; after rst_n rises, the first start is accepted normally.

Verification
REQ-038 SETTLE_CYCLES=2, gate_sel=0, correct AND model, start at E0 -> done pulses after E12, pass=1, err_count=0, invalid=0.
REQ-039 gate_sel=1, dut_y stuck at 0 -> err_count=3, first_fail_vec=2'b01, pass=0.
REQ-040 gate_sel=2, dut_y=~dut_a -> pass=1; repeat with dut_y=dut_a -> err_count=4, first_fail_vec=2'b00.
REQ-041 gate_sel=7 -> done one cycle after start, invalid=1, pass=0, dut_a=dut_b=0 throughout.
REQ-042 start pulsed again at E5 with gate_sel changed to 5 -> ignored; the AND run completes at E12 unaffected.
REQ-043 rst_n low at E7 of an AND run -> all outputs 0 at once, no done pulse; the next start runs a full 12-cycle test.

Source files
------------

// File: rtl/gate_checker.sv
// rtl/gate_checker.sv - exhaustive two-input logic gate tester
// Walks vectors 00..11, holds each for SETTLE_CYCLES+1 cycles and compares dut_y on the last edge.
module gate_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       invalid,
    output logic [2:0] err_count,
    output logic [1:0] first_fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // With no settle time a vector goes straight to its comparison cycle.
    localparam logic [3:0] CNT_INIT   = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam state_t     HOLD_STATE = (SETTLE_CYCLES > 0) ? S_SETTLE : S_COMPARE;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [2:0] r_gate;
    logic [1:0] r_vec;
    logic       r_dut_a;
    logic       r_dut_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic       r_invalid;
    logic [2:0] r_err;
    logic [1:0] r_ffv;

    logic       w_a;
    logic       w_b;
    logic       w_expected;
    logic       w_mismatch;
    logic [2:0] w_err_next;

    assign w_a = r_vec[1];
    assign w_b = r_vec[0];

    always_comb begin
        w_expected = 1'b0;
        case (r_gate)
            3'd0:    w_expected = w_a & w_b;
            3'd1:    w_expected = w_a | w_b;
            3'd2:    w_expected = ~w_a;
            3'd3:    w_expected = ~(w_a & w_b);
            3'd4:    w_expected = ~(w_a | w_b);
            3'd5:    w_expected = w_a ^ w_b;
            3'd6:    w_expected = ~(w_a ^ w_b);
            default: w_expected = 1'b0;
        endcase
    end

    assign w_mismatch = (dut_y != w_expected);
    assign w_err_next = r_err + {2'b00, w_mismatch};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_gate    <= 3'd0;
            r_vec     <= 2'd0;
            r_dut_a   <= 1'b0;
            r_dut_b   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_invalid <= 1'b0;
            r_err     <= 3'd0;
            r_ffv     <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_gate    <= gate_sel;
                        r_pass    <= 1'b0;
                        r_invalid <= 1'b0;
                        r_err     <= 3'd0;
                        r_ffv     <= 2'd0;
                        if (gate_sel == 3'd7) begin
                            r_invalid <= 1'b1;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_vec   <= 2'd0;
                            r_dut_a <= 1'b0;
                            r_dut_b <= 1'b0;
                            r_cnt   <= CNT_INIT;
                            r_state <= HOLD_STATE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_COMPARE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_COMPARE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && (r_err == 3'd0)) begin
                        r_ffv <= r_vec;
                    end
                    if (r_vec == 2'd3) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == 3'd0);
                        r_dut_a <= 1'b0;
                        r_dut_b <= 1'b0;
                        r_vec   <= 2'd0;
                    end else begin
                        // Next vector launches on the same edge that judged the previous one.
                        r_vec   <= r_vec + 2'd1;
                        {r_dut_a, r_dut_b} <= r_vec + 2'd1;
                        r_cnt   <= CNT_INIT;
                        r_state <= HOLD_STATE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dut_a          = r_dut_a;
    assign dut_b          = r_dut_b;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign invalid        = r_invalid;
    assign err_count      = r_err;
    assign first_fail_vec = r_ffv;

endmodule
